// File: rtl/mantissa_adder.sv
// Responder side of the FPU mantissa-add handshake: captures two 25-bit operands,
// adds them CHUNK bits per cycle, then returns {carry, sum} with a one-cycle ack.
module mantissa_adder #(
  parameter int CHUNK = 5
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        Adder_valid,
  input  logic [24:0] Adder_datain1,
  input  logic [24:0] Adder_datain2,
  output logic [24:0] Adder_dataout,
  output logic        Adder_carryout,
  output logic        Adder_ack,
  output logic        Busy
);
  localparam int WIDTH  = 25;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, ADD, ACK, WAIT_REL} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg, sum_next;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CHUNK:0]   chunk_sum;
  logic             accept, last_chunk;

  // Operands shift right each ADD cycle, so the live chunk is always the low CHUNK bits.
  assign chunk_sum = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_reg};

  // Sum chunks enter at the top; after NCHUNK insertions chunk 0 sits at bit 0.
  if (NCHUNK > 1) begin : g_multi
    assign sum_next = {chunk_sum[CHUNK-1:0], sum_reg[WIDTH-1:CHUNK]};
  end else begin : g_single
    assign sum_next = chunk_sum[CHUNK-1:0];
  end

  assign accept     = (state_reg == IDLE) && Adder_valid;
  assign last_chunk = (state_reg == ADD) && (cnt_reg == LAST);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    Adder_ack  = 1'b0;
    Busy       = 1'b1;
    unique case (state_reg)
      IDLE: begin
        Busy = 1'b0;
        if (Adder_valid) state_next = ADD;
      end
      ADD: begin
        if (cnt_reg == LAST) state_next = ACK;
      end
      ACK: begin
        Adder_ack  = 1'b1;
        state_next = WAIT_REL;
      end
      WAIT_REL: begin
        // A stale high request must not relaunch an add.
        if (!Adder_valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      a_reg          <= '0;
      b_reg          <= '0;
      sum_reg        <= '0;
      carry_reg      <= 1'b0;
      cnt_reg        <= '0;
      Adder_dataout  <= '0;
      Adder_carryout <= 1'b0;
    end else if (accept) begin
      a_reg     <= Adder_datain1;
      b_reg     <= Adder_datain2;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
    end else if (state_reg == ADD) begin
      a_reg     <= a_reg >> CHUNK;
      b_reg     <= b_reg >> CHUNK;
      sum_reg   <= sum_next;
      carry_reg <= chunk_sum[CHUNK];
      cnt_reg   <= cnt_reg + CNT_W'(1);
      if (last_chunk) begin
        Adder_dataout  <= sum_next;
        Adder_carryout <= chunk_sum[CHUNK];
      end
    end
  end

endmodule
